// File: rtl/mult_leak_sweep_driver_pkg.sv
// Shared state encoding, default timing constants and sizing helper for the
// multiplier leak sweep driver.
package mult_leak_sweep_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } sweepState_e;

  localparam int DEFAULT_TIMEOUT    = 64;
  localparam int DEFAULT_GAP_CYCLES = 2;

  // One counter serves both the WAIT timeout and the GAP, so size it for the larger.
  function automatic int timerWidth(input int timeout, input int gapCycles);
    int maxCount;
    maxCount = (timeout > gapCycles) ? timeout : gapCycles;
    return (maxCount < 2) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/mult_leak_sweep_driver_timer.sv
// Shared WAIT/GAP cycle counter: cleared by load, advanced by en, and flags
// when it sits on the limit selected by the sequencer.
module mult_leak_trial_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          expired
);

  logic [CW-1:0] count_r;

  // Cycle counter; load has priority so a new phase always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign expired = (count_r == limit);

endmodule

// File: rtl/mult_leak_sweep_driver.sv
// Sweep sequencer for the two-copy multiplier leak tester: walks every operand
// index, issues one start per trial and accumulates the leak/timeout results.
module mult_leak_sweep_driver
  import mult_leak_sweep_driver_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               start,
  output logic [WIDTH-1:0]   multiplierOne,
  output logic [WIDTH-1:0]   multiplicandOne,
  output logic [WIDTH-1:0]   multiplierTwo,
  output logic [WIDTH-1:0]   multiplicandTwo,
  input  logic               timingLeakDone,
  input  logic               timingLeak,
  output logic               busy,
  output logic               sweepDone,
  output logic               leakFound,
  output logic [2*WIDTH:0]   leakCount,
  output logic [2*WIDTH-1:0] firstLeakIdx,
  output logic               timeoutErr,
  output logic [2*WIDTH-1:0] curIdx
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = timerWidth(TIMEOUT, GAP_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  sweepState_e   state_r;
  logic          start_r;
  logic          busy_r;
  logic          sweepDone_r;
  logic          leakFound_r;
  logic          timeoutErr_r;
  logic [IW:0]   leakCount_r;
  logic [IW-1:0] firstLeakIdx_r;
  logic [IW-1:0] curIdx_r;

  logic          timerLoad_s;
  logic          timerEn_s;
  logic          timerExpired_s;
  logic          sample_s;
  logic [CW-1:0] timerLimit_s;
  logic [CW-1:0] timerCount_s;

  mult_leak_trial_timer #(.CW(CW)) trialTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (timerLoad_s),
    .en      (timerEn_s),
    .limit   (timerLimit_s),
    .count   (timerCount_s),
    .expired (timerExpired_s)
  );

  // Timer control; counter 0 of WAIT ignores a done level left over from the previous trial.
  always_comb begin
    timerLoad_s  = 1'b0;
    timerEn_s    = 1'b0;
    timerLimit_s = WAIT_LAST;
    sample_s     = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        timerLoad_s = 1'b1;
      end
      ST_WAIT: begin
        sample_s    = timingLeakDone && (timerCount_s != {CW{1'b0}});
        timerLoad_s = sample_s || timerExpired_s;
        timerEn_s   = 1'b1;
      end
      ST_GAP: begin
        timerEn_s    = 1'b1;
        timerLimit_s = GAP_LAST;
      end
      default: begin
        timerLoad_s = 1'b0;
      end
    endcase
  end

  // Sweep FSM with registered start/busy and sticky result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      start_r        <= 1'b0;
      busy_r         <= 1'b0;
      sweepDone_r    <= 1'b0;
      leakFound_r    <= 1'b0;
      timeoutErr_r   <= 1'b0;
      leakCount_r    <= {(IW + 1){1'b0}};
      firstLeakIdx_r <= {IW{1'b0}};
      curIdx_r       <= {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            sweepDone_r    <= 1'b0;
            leakFound_r    <= 1'b0;
            timeoutErr_r   <= 1'b0;
            leakCount_r    <= {(IW + 1){1'b0}};
            firstLeakIdx_r <= {IW{1'b0}};
            curIdx_r       <= {IW{1'b0}};
            start_r        <= 1'b1;
            busy_r         <= 1'b1;
            state_r        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_r <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sample_s) begin
            if (timingLeak) begin
              leakCount_r <= leakCount_r + {{IW{1'b0}}, 1'b1};
              if (!leakFound_r) begin
                leakFound_r    <= 1'b1;
                firstLeakIdx_r <= curIdx_r;
              end
            end
            state_r <= ST_GAP;
          end else if (timerExpired_s) begin
            timeoutErr_r <= 1'b1;
            state_r      <= ST_FINISH;
          end
        end
        ST_GAP: begin
          if (timerExpired_s) begin
            if (&curIdx_r) begin
              state_r <= ST_FINISH;
            end else begin
              curIdx_r <= curIdx_r + {{(IW - 1){1'b0}}, 1'b1};
              start_r  <= 1'b1;
              state_r  <= ST_ISSUE;
            end
          end
        end
        ST_FINISH: begin
          sweepDone_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          start_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign start        = start_r;
  assign busy         = busy_r;
  assign sweepDone    = sweepDone_r;
  assign leakFound    = leakFound_r;
  assign timeoutErr   = timeoutErr_r;
  assign leakCount    = leakCount_r;
  assign firstLeakIdx = firstLeakIdx_r;
  assign curIdx       = curIdx_r;

  assign {multiplierOne, multiplicandOne} = curIdx_r;
  assign {multiplierTwo, multiplicandTwo} = ~curIdx_r;

endmodule

// File: tb/tb_mult_leak_sweep_driver.sv
// Randomized bench for mult_leak_sweep_driver with a behavioural tester stub
// and an arithmetic reference model of the sweep results.
module tb_mult_leak_sweep_driver;

  localparam int W   = 2;
  localparam int TO  = 8;
  localparam int GAP = 2;
  localparam int IW  = 2 * W;
  localparam int N   = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic start, busy, sweepDone, leakFound, timeoutErr;
  logic timingLeakDone, timingLeak;
  logic [W-1:0]  multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo;
  logic [IW:0]   leakCount;
  logic [IW-1:0] firstLeakIdx, curIdx;

  int checks = 0;
  int failures = 0;

  // Stub tester configuration: per-index done delay (cycles after start) and leak flag.
  int delayTab [N];
  bit leakTab  [N];
  bit holdMode  = 1'b0;
  bit neverDone = 1'b0;
  int age = 0;
  logic [IW-1:0] stubIdx = '0;
  logic prevDone = 1'b0;
  logic prevLeak = 1'b0;

  int startCycle  [64];
  int startIdxObs [64];

  always #5 clk = ~clk;

  mult_leak_sweep_driver #(.WIDTH(W), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .run(run), .start(start),
    .multiplierOne(multiplierOne), .multiplicandOne(multiplicandOne),
    .multiplierTwo(multiplierTwo), .multiplicandTwo(multiplicandTwo),
    .timingLeakDone(timingLeakDone), .timingLeak(timingLeak),
    .busy(busy), .sweepDone(sweepDone), .leakFound(leakFound),
    .leakCount(leakCount), .firstLeakIdx(firstLeakIdx),
    .timeoutErr(timeoutErr), .curIdx(curIdx)
  );

  // Stub age: 1 in the first cycle after the start pulse.
  always @(posedge clk) begin
    if (!rst) begin
      age <= 0; prevDone <= 1'b0; prevLeak <= 1'b0;
    end else begin
      prevDone <= timingLeakDone;
      prevLeak <= timingLeak;
      if (start === 1'b1) begin
        age <= 1; stubIdx <= curIdx;
      end else if (age != 0 && age < 1000) begin
        age <= age + 1;
      end
    end
  end

  // Pulse mode: done for one cycle; hold mode: done stays high (stale) into the next trial.
  always_comb begin
    if (neverDone || age == 0) begin
      timingLeakDone = 1'b0; timingLeak = 1'b0;
    end else if (holdMode && age == 1) begin
      timingLeakDone = prevDone; timingLeak = prevLeak;
    end else if (holdMode) begin
      timingLeakDone = (age >= delayTab[stubIdx]); timingLeak = leakTab[stubIdx];
    end else begin
      timingLeakDone = (age == delayTab[stubIdx]); timingLeak = leakTab[stubIdx];
    end
  end

  task automatic setTables(input bit randomize, input int fixedDelay);
    for (int i = 0; i < N; i++) begin
      delayTab[i] = randomize ? int'($urandom_range(TO, 2)) : fixedDelay;
      leakTab[i]  = randomize ? ($urandom_range(3, 0) == 0) : 1'b0;
    end
  endtask

  // Pulses run from a negedge and records start pulses until sweepDone or budget.
  task automatic runSweep(output int starts, output bit finished, output int doneCycle);
    starts = 0; finished = 1'b0; doneCycle = -1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (start === 1'b1 && starts < 64) begin
        startCycle[starts] = cyc; startIdxObs[starts] = int'(curIdx); starts++;
      end
      if (sweepDone === 1'b1) begin
        finished = 1'b1; doneCycle = cyc; break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({start, busy, sweepDone, leakFound, timeoutErr} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {start, busy, sweepDone, leakFound, timeoutErr}); end
    checks++; if (leakCount !== '0) begin failures++; $display("FAIL reset_leakCount got=%0d exp=0", leakCount); end
    checks++; if (firstLeakIdx !== '0) begin failures++; $display("FAIL reset_firstLeakIdx got=%0d exp=0", firstLeakIdx); end
    checks++; if (curIdx !== '0) begin failures++; $display("FAIL reset_curIdx got=%0d exp=0", curIdx); end
    checks++; if ({multiplierOne, multiplicandOne} !== 4'h0) begin failures++; $display("FAIL reset_opsOne got=%h exp=0", {multiplierOne, multiplicandOne}); end
    checks++; if ({multiplierTwo, multiplicandTwo} !== 4'hF) begin failures++; $display("FAIL reset_opsTwo got=%h exp=f", {multiplierTwo, multiplicandTwo}); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({start, busy} !== 2'b00) begin failures++; $display("FAIL idle_noRun got=%b exp=00", {start, busy}); end
  endtask

  task automatic test_clean_sweep();
    int starts, doneCycle, bad;
    bit fin;
    holdMode = 1'b0; neverDone = 1'b0;
    setTables(1'b0, 3);
    runSweep(starts, fin, doneCycle);
    checks++; if (!fin || starts != N) begin failures++; $display("FAIL clean_starts got=%0d fin=%0d exp=%0d fin=1", starts, fin, N); end
    checks++; if (startCycle[0] != 0) begin failures++; $display("FAIL clean_firstStartLatency got=%0d exp=0", startCycle[0]); end
    checks++; if ({leakFound, timeoutErr, busy} !== 3'b000 || leakCount !== '0) begin failures++; $display("FAIL clean_results got lf=%b to=%b busy=%b lc=%0d exp all 0", leakFound, timeoutErr, busy, leakCount); end
    bad = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (startCycle[i + 1] - startCycle[i] != 1 + delayTab[i] + GAP) bad++;
      if (startIdxObs[i] != i) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL clean_trialSpacing got=%0d bad trials exp=0", bad); end
    checks++; if (doneCycle - startCycle[N - 1] != delayTab[N - 1] + GAP + 2) begin failures++; $display("FAIL clean_finishLatency got=%0d exp=%0d", doneCycle - startCycle[N - 1], delayTab[N - 1] + GAP + 2); end
  endtask

  task automatic test_leak_sweep();
    int starts, doneCycle, bad;
    bit fin, found;
    logic [IW:0] expCount;
    logic [IW-1:0] expFirst;
    holdMode = 1'b0; neverDone = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 0) begin
        setTables(1'b0, 3); leakTab[5] = 1'b1;
      end else begin
        setTables(1'b1, 0);
      end
      expCount = '0; expFirst = '0; found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (leakTab[i]) begin
          expCount++;
          if (!found) begin found = 1'b1; expFirst = IW'(i); end
        end
      end
      runSweep(starts, fin, doneCycle);
      checks++; if (!fin || starts != N) begin failures++; $display("FAIL leak_starts pass=%0d got=%0d exp=%0d", pass, starts, N); end
      checks++; if (leakFound !== found) begin failures++; $display("FAIL leak_found pass=%0d got=%b exp=%b", pass, leakFound, found); end
      checks++; if (leakCount !== expCount) begin failures++; $display("FAIL leak_count pass=%0d got=%0d exp=%0d", pass, leakCount, expCount); end
      checks++; if (firstLeakIdx !== expFirst) begin failures++; $display("FAIL leak_firstIdx pass=%0d got=%0d exp=%0d", pass, firstLeakIdx, expFirst); end
      checks++; if (timeoutErr !== 1'b0) begin failures++; $display("FAIL leak_timeout pass=%0d got=%b exp=0", pass, timeoutErr); end
      bad = 0;
      for (int i = 0; i < N - 1; i++) if (startCycle[i + 1] - startCycle[i] != 1 + delayTab[i] + GAP) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL leak_trialSpacing pass=%0d got=%0d bad exp=0", pass, bad); end
    end
  endtask

  task automatic test_operands();
    int trial, expIdx, bad, spot;
    logic [W-1:0] e1, e2, e3, e4, s1, s2, s3, s4;
    bit spotSeen;
    holdMode = 1'b0; neverDone = 1'b0;
    setTables(1'b1, 0);
    spot = int'($urandom_range(N - 1, 0));
    trial = -1; expIdx = 0; bad = 0; spotSeen = 1'b0;
    s1 = '0; s2 = '0; s3 = '0; s4 = '0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (start === 1'b1) begin
        trial++; expIdx = trial;
        if (expIdx == spot) begin
          spotSeen = 1'b1; s1 = multiplierOne; s2 = multiplicandOne; s3 = multiplierTwo; s4 = multiplicandTwo;
        end
      end
      if (trial >= 0) begin
        e1 = W'(expIdx / (1 << W));
        e2 = W'(expIdx % (1 << W));
        e3 = W'((1 << W) - 1 - expIdx / (1 << W));
        e4 = W'((1 << W) - 1 - expIdx % (1 << W));
        if (multiplierOne !== e1 || multiplicandOne !== e2 || multiplierTwo !== e3 || multiplicandTwo !== e4) bad++;
      end
      if (sweepDone === 1'b1) break;
      @(negedge clk);
    end
    checks++; if (trial != N - 1) begin failures++; $display("FAIL ops_trials got=%0d exp=%0d", trial + 1, N); end
    checks++; if (bad != 0) begin failures++; $display("FAIL ops_stable got=%0d bad cycles exp=0", bad); end
    checks++; if (!spotSeen || s1 !== W'(spot / (1 << W)) || s2 !== W'(spot % (1 << W))) begin failures++; $display("FAIL ops_spotOne idx=%0d got=%0d,%0d", spot, s1, s2); end
    checks++; if (!spotSeen || s3 !== W'((1 << W) - 1 - spot / (1 << W)) || s4 !== W'((1 << W) - 1 - spot % (1 << W))) begin failures++; $display("FAIL ops_spotTwo idx=%0d got=%0d,%0d", spot, s3, s4); end
  endtask

  task automatic test_timeout();
    int starts, doneCycle;
    bit fin;
    holdMode = 1'b0; neverDone = 1'b1;
    setTables(1'b0, 3);
    runSweep(starts, fin, doneCycle);
    checks++; if (!fin || starts != 1) begin failures++; $display("FAIL to_starts got=%0d fin=%0d exp=1 fin=1", starts, fin); end
    checks++; if (timeoutErr !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeoutErr); end
    checks++; if (curIdx !== '0) begin failures++; $display("FAIL to_curIdx got=%0d exp=0", curIdx); end
    checks++; if (doneCycle - startCycle[0] != TO + 2) begin failures++; $display("FAIL to_waitCycles got=%0d exp=%0d", doneCycle - startCycle[0], TO + 2); end
    checks++; if ({leakFound, busy} !== 2'b00 || leakCount !== '0) begin failures++; $display("FAIL to_results got lf=%b busy=%b lc=%0d exp 0", leakFound, busy, leakCount); end
    // A done pulse only in the first WAIT cycle must be masked, so this also times out.
    neverDone = 1'b0;
    setTables(1'b0, 1);
    runSweep(starts, fin, doneCycle);
    checks++; if (!fin || starts != 1 || timeoutErr !== 1'b1) begin failures++; $display("FAIL to_maskedDone got starts=%0d to=%b exp starts=1 to=1", starts, timeoutErr); end
  endtask

  task automatic test_reset_mid_sweep();
    int starts, doneCycle;
    bit fin, hit;
    holdMode = 1'b0; neverDone = 1'b0;
    setTables(1'b0, 3);
    leakTab[2] = 1'b1;
    hit = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (start === 1'b1 && curIdx === 4'd7) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_reachTrial7 got=0 exp=1"); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({start, busy, sweepDone, leakFound, timeoutErr} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {start, busy, sweepDone, leakFound, timeoutErr}); end
    checks++; if (leakCount !== '0 || firstLeakIdx !== '0 || curIdx !== '0) begin failures++; $display("FAIL rst_regs got lc=%0d fi=%0d ci=%0d exp 0", leakCount, firstLeakIdx, curIdx); end
    checks++; if ({multiplierTwo, multiplicandTwo} !== 4'hF) begin failures++; $display("FAIL rst_opsTwo got=%h exp=f", {multiplierTwo, multiplicandTwo}); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({sweepDone, busy, start} !== 3'b000) begin failures++; $display("FAIL rst_noFinish got=%b exp=000", {sweepDone, busy, start}); end
    leakTab[2] = 1'b0;
    runSweep(starts, fin, doneCycle);
    checks++; if (!fin || starts != N || startIdxObs[0] != 0) begin failures++; $display("FAIL rst_restart got starts=%0d idx0=%0d exp %0d,0", starts, startIdxObs[0], N); end
    checks++; if ({leakFound, timeoutErr} !== 2'b00 || leakCount !== '0) begin failures++; $display("FAIL rst_restartFlags got lf=%b to=%b lc=%0d exp 0", leakFound, timeoutErr, leakCount); end
  endtask

  task automatic test_back_to_back();
    int starts, sweeps, doneAt;
    bit found, prevSd, sawNext;
    logic nxtStart, nxtSd, lf1;
    logic [IW:0] expCount, lc1, lc2, nxtLc;
    logic [IW-1:0] expFirst, ff1, ff2;
    holdMode = 1'b1; neverDone = 1'b0;
    setTables(1'b1, 0);
    leakTab[0] = 1'b1;
    leakTab[1] = 1'b0;
    expCount = '0; expFirst = '0; found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (leakTab[i]) begin
        expCount++;
        if (!found) begin found = 1'b1; expFirst = IW'(i); end
      end
    end
    starts = 0; sweeps = 0; doneAt = -10; prevSd = 1'b0; sawNext = 1'b0;
    nxtStart = 1'b0; nxtSd = 1'b1; nxtLc = '1; lf1 = 1'b0;
    lc1 = '0; lc2 = '0; ff1 = '0; ff2 = '0;
    run = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (start === 1'b1) starts++;
      if (sweeps == 1 && cyc == doneAt + 1) begin
        sawNext = 1'b1; nxtStart = start; nxtSd = sweepDone; nxtLc = leakCount;
      end
      if (sweepDone === 1'b1 && !prevSd) begin
        sweeps++; doneAt = cyc;
        if (sweeps == 1) begin
          lc1 = leakCount; ff1 = firstLeakIdx; lf1 = leakFound;
        end else begin
          lc2 = leakCount; ff2 = firstLeakIdx; break;
        end
      end
      prevSd = sweepDone;
      @(negedge clk);
    end
    run = 1'b0;
    checks++; if (sweeps != 2 || starts != 2 * N) begin failures++; $display("FAIL b2b_starts got sweeps=%0d starts=%0d exp 2,%0d", sweeps, starts, 2 * N); end
    checks++; if (lc1 !== expCount || lc2 !== expCount) begin failures++; $display("FAIL b2b_leakCount got=%0d,%0d exp=%0d", lc1, lc2, expCount); end
    checks++; if (ff1 !== expFirst || ff2 !== expFirst || lf1 !== found) begin failures++; $display("FAIL b2b_firstIdx got=%0d,%0d lf=%b exp=%0d lf=%b", ff1, ff2, lf1, expFirst, found); end
    checks++; if (!sawNext || nxtStart !== 1'b1 || nxtSd !== 1'b0 || nxtLc !== '0) begin failures++; $display("FAIL b2b_restart got start=%b sd=%b lc=%0d exp 1,0,0", nxtStart, nxtSd, nxtLc); end
    checks++; if (timeoutErr !== 1'b0) begin failures++; $display("FAIL b2b_timeout got=%b exp=0", timeoutErr); end
    holdMode = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_leak_sweep();
    test_operands();
    test_timeout();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
